// File: rtl/mips_pkg.sv
// Shared definitions for the data memory path: memory geometry, read-return
// owner encodings and the arbiter state encodings.
package mips_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;

  // Who owns the read data coming back from the memory this cycle.
  typedef enum logic [1:0] {
    RD_NONE = 2'b00,
    RD_PIPE = 2'b01,
    RD_EXT  = 2'b10
  } rd_owner_t;

  // PIPE_PRI: pipeline wins contention. EXT_FORCE: external port wins once.
  typedef enum logic {
    ARB_PIPE_PRI  = 1'b0,
    ARB_EXT_FORCE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dm_starve_counter.sv
// Counts consecutive cycles in which the external port asked for the memory
// and was refused. Raises force_next in the refused cycle that reaches
// limit-1, so the arbiter can hand the external port the next slot.
module dm_starve_counter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic       clk4,
  input  logic       rst_n,
  input  logic       req,
  input  logic       granted,
  output logic [3:0] cnt,
  output logic       force_next
);

  localparam logic [3:0] LIMIT_C    = 4'(STARVE_LIMIT);
  localparam logic [3:0] LIMIT_M1_C = 4'(STARVE_LIMIT - 1);

  // Refused-request detection and force condition for the arbiter FSM.
  always_comb begin
    force_next = req & ~granted & (cnt == LIMIT_M1_C);
  end

  // Saturating count of refused cycles; cleared by a grant or a dropped request.
  always_ff @(posedge clk4 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (!req || granted) begin
      cnt <= 4'd0;
    end else if (cnt < LIMIT_C) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage and an
// external loader/debug port. The pipeline normally wins; after the external
// port has been refused STARVE_LIMIT cycles in a row it gets one forced slot
// and the pipeline is stalled for that cycle.
//
// Handshake: the external port raises ext_req and holds ext_rw/addr/wdata
// stable until ext_gnt is seen high at a clock edge; ext_gnt is a one-cycle
// acceptance. A granted read returns ext_rdata with ext_rvalid one cycle
// later. The pipeline holds its inputs while pipe_stall is high; a granted
// pipeline read returns on pipe_rdata one cycle later.
module data_mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W       = MEM_ADDR_W,
  parameter int DATA_W       = MEM_DATA_W,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk4,
  input  logic              rst_n,
  input  logic              pipe_en,
  input  logic              pipe_rw,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_stall,
  input  logic              ext_req,
  input  logic              ext_rw,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  input  logic [DATA_W-1:0] mem_douta,
  output logic              dbg_state,
  output logic [3:0]        dbg_starve_cnt
);

  arb_state_t state;
  rd_owner_t  rd_owner;
  logic       grant_ext;
  logic       grant_pipe;
  logic       force_next;
  logic [3:0] starve_cnt;

  dm_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk4      (clk4),
    .rst_n     (rst_n),
    .req       (ext_req),
    .granted   (grant_ext),
    .cnt       (starve_cnt),
    .force_next(force_next)
  );

  // Per-cycle grant decision; nothing is granted while reset is asserted.
  always_comb begin
    grant_ext  = rst_n & ext_req & (~pipe_en | (state == ARB_EXT_FORCE));
    grant_pipe = rst_n & pipe_en & ~grant_ext;
  end

  // Memory port mux from the granted requester; idle drives all zeros.
  always_comb begin
    mem_ena   = 1'b0;
    mem_wea   = 1'b0;
    mem_addra = '0;
    mem_dina  = '0;
    if (grant_ext) begin
      mem_ena   = 1'b1;
      mem_wea   = ext_rw;
      mem_addra = ext_addr;
      mem_dina  = ext_wdata;
    end else if (grant_pipe) begin
      mem_ena   = 1'b1;
      mem_wea   = pipe_rw;
      mem_addra = pipe_addr;
      mem_dina  = pipe_wdata;
    end
  end

  // Handshake and read-return outputs.
  always_comb begin
    ext_gnt        = grant_ext;
    pipe_stall     = rst_n & pipe_en & grant_ext;
    ext_rvalid     = (rd_owner == RD_EXT);
    pipe_rdata     = mem_douta;
    ext_rdata      = mem_douta;
    dbg_state      = state;
    dbg_starve_cnt = starve_cnt;
  end

  // Priority FSM: one forced external slot after starvation, then back.
  always_ff @(posedge clk4 or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_PIPE_PRI;
    end else begin
      case (state)
        ARB_PIPE_PRI:  if (force_next) state <= ARB_EXT_FORCE;
        ARB_EXT_FORCE: if (grant_ext)  state <= ARB_PIPE_PRI;
        default:                       state <= ARB_PIPE_PRI;
      endcase
    end
  end

  // Remember which port issued this cycle's read so its data is steered next cycle.
  always_ff @(posedge clk4 or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner <= RD_NONE;
    end else if (grant_ext && !ext_rw) begin
      rd_owner <= RD_EXT;
    end else if (grant_pipe && !pipe_rw) begin
      rd_owner <= RD_PIPE;
    end else begin
      rd_owner <= RD_NONE;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 256x8 sync-read
// memory attached to the mem_* port.
module tb_data_mem_arbiter;

  logic       clk4;
  logic       rst_n;
  logic       pipe_en, pipe_rw;
  logic [7:0] pipe_addr, pipe_wdata, pipe_rdata;
  logic       pipe_stall;
  logic       ext_req, ext_rw;
  logic [7:0] ext_addr, ext_wdata, ext_rdata;
  logic       ext_gnt, ext_rvalid;
  logic       mem_ena, mem_wea;
  logic [7:0] mem_addra, mem_dina, mem_douta;
  logic       dbg_state;
  logic [3:0] dbg_starve_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];       // expected ext read data, in order
  logic [7:0] pipe_q[$];      // expected pipe read data, in order
  logic [7:0] mem_arr[256];   // behavioural memory
  logic [7:0] ref_mem[256];   // bench's view of what memory should hold
  logic [7:0] d6[3];

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(3)) dut (
    .clk4(clk4), .rst_n(rst_n),
    .pipe_en(pipe_en), .pipe_rw(pipe_rw), .pipe_addr(pipe_addr),
    .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .ext_req(ext_req), .ext_rw(ext_rw), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .ext_rdata(ext_rdata),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra),
    .mem_dina(mem_dina), .mem_douta(mem_douta),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // Clock and watchdog.
  initial clk4 = 1'b0;
  always #5 clk4 = ~clk4;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  // Behavioural memory: sync read with 1-cycle latency, read-first on write.
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 8'(i ^ 8'hA5);
      ref_mem[i] = 8'(i ^ 8'hA5);
    end
    mem_douta = 8'h00;
  end

  always @(posedge clk4) begin
    if (mem_ena) begin
      if (mem_wea) mem_arr[mem_addra] <= mem_dina;
      mem_douta <= mem_arr[mem_addra];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk4);
    #1;
  endtask

  task automatic mid();
    @(negedge clk4);
  endtask

  // Scoreboard: every ext_rvalid pops one expected value.
  always @(negedge clk4) begin
    if (ext_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("ext_spurious_rvalid", ext_rvalid, 0);
      end else begin
        chk("ext_rdata", ext_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    pipe_en = 1'b1; pipe_rw = 1'b0; pipe_addr = 8'h00; pipe_wdata = 8'h00;
    ext_req = 1'b1; ext_rw = 1'b0; ext_addr = 8'h00; ext_wdata = 8'h00;

    // 1: reset with both requesters active
    mid();
    chk("rst_mem_ena", mem_ena, 0);
    chk("rst_ext_gnt", ext_gnt, 0);
    chk("rst_pipe_stall", pipe_stall, 0);
    chk("rst_ext_rvalid", ext_rvalid, 0);
    chk("rst_mem_wea", mem_wea, 0);
    next_cycle();
    next_cycle();
    chk("rst_state", dbg_state, 0);
    chk("rst_starve", dbg_starve_cnt, 0);
    rst_n = 1'b1; pipe_en = 1'b0; ext_req = 1'b0;
    mid();
    chk("idle_mem_ena", mem_ena, 0);

    // 2: pipeline write then read
    next_cycle();
    pipe_en = 1'b1; pipe_rw = 1'b1; pipe_addr = 8'h10; pipe_wdata = 8'h5A;
    ref_mem[8'h10] = 8'h5A;
    mid();
    chk("t2_wr_ena", mem_ena, 1);
    chk("t2_wr_wea", mem_wea, 1);
    chk("t2_wr_addr", mem_addra, 8'h10);
    chk("t2_wr_din", mem_dina, 8'h5A);
    chk("t2_wr_stall", pipe_stall, 0);
    next_cycle();
    pipe_rw = 1'b0;
    pipe_q.push_back(ref_mem[8'h10]);
    mid();
    chk("t2_rd_ena", mem_ena, 1);
    chk("t2_rd_wea", mem_wea, 0);
    chk("t2_rd_stall", pipe_stall, 0);
    next_cycle();
    pipe_en = 1'b0;
    mid();
    chk("t2_pipe_rdata", pipe_rdata, pipe_q.pop_front());
    chk("t2_no_ext_rvalid", ext_rvalid, 0);
    chk("t2_idle_ena", mem_ena, 0);

    // 3: external write then read
    next_cycle();
    ext_req = 1'b1; ext_rw = 1'b1; ext_addr = 8'h20; ext_wdata = 8'hC3;
    ref_mem[8'h20] = 8'hC3;
    mid();
    chk("t3_wr_gnt", ext_gnt, 1);
    chk("t3_wr_wea", mem_wea, 1);
    chk("t3_wr_addr", mem_addra, 8'h20);
    next_cycle();
    ext_rw = 1'b0;
    exp_q.push_back(ref_mem[8'h20]);
    mid();
    chk("t3_rd_gnt", ext_gnt, 1);
    chk("t3_no_rvalid_after_wr", ext_rvalid, 0);
    next_cycle();
    ext_req = 1'b0;
    mid();
    chk("t3_rvalid", ext_rvalid, 1);
    next_cycle();
    mid();
    chk("t3_rvalid_drop", ext_rvalid, 0);

    // 4: contention, starvation forces one ext slot in cycle 3
    next_cycle();
    pipe_en = 1'b1; pipe_rw = 1'b0; pipe_addr = 8'h10;
    ext_req = 1'b1; ext_rw = 1'b1; ext_addr = 8'h30; ext_wdata = 8'hD7;
    for (int c = 0; c < 3; c++) begin
      mid();
      chk($sformatf("t4_c%0d_gnt", c), ext_gnt, 0);
      chk($sformatf("t4_c%0d_stall", c), pipe_stall, 0);
      chk($sformatf("t4_c%0d_addr", c), mem_addra, 8'h10);
      chk($sformatf("t4_c%0d_starve", c), dbg_starve_cnt, c);
      next_cycle();
    end
    ref_mem[8'h30] = 8'hD7;
    mid();
    chk("t4_c3_gnt", ext_gnt, 1);
    chk("t4_c3_stall", pipe_stall, 1);
    chk("t4_c3_state", dbg_state, 1);
    chk("t4_c3_addr", mem_addra, 8'h30);
    chk("t4_c3_wea", mem_wea, 1);
    next_cycle();
    ext_req = 1'b0;
    pipe_addr = 8'h30;
    pipe_q.push_back(ref_mem[8'h30]);
    mid();
    chk("t4_c4_gnt", ext_gnt, 0);
    chk("t4_c4_stall", pipe_stall, 0);
    chk("t4_c4_ena", mem_ena, 1);
    chk("t4_c4_addr", mem_addra, 8'h30);
    chk("t4_c4_starve", dbg_starve_cnt, 0);
    chk("t4_c4_state", dbg_state, 0);
    next_cycle();
    pipe_en = 1'b0;
    mid();
    chk("t4_raw_pipe_rdata", pipe_rdata, pipe_q.pop_front());

    // 5: reset between an ext read grant and its return
    next_cycle();
    ext_req = 1'b1; ext_rw = 1'b0; ext_addr = 8'h20;
    mid();
    chk("t5_gnt", ext_gnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ena", mem_ena, 0);
    chk("t5_rst_gnt", ext_gnt, 0);
    next_cycle();
    rst_n = 1'b1; ext_req = 1'b0;
    mid();
    chk("t5_rvalid_dropped", ext_rvalid, 0);
    next_cycle();
    mid();
    chk("t5_rvalid_still0", ext_rvalid, 0);

    // 6: back-to-back ext reads after seeding 0x00..0x02 via the pipeline
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      d6[i] = 8'($urandom_range(0, 255));
      pipe_en = 1'b1; pipe_rw = 1'b1; pipe_addr = 8'(i); pipe_wdata = d6[i];
      ref_mem[i] = d6[i];
    end
    next_cycle();
    pipe_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ext_req = 1'b1; ext_rw = 1'b0; ext_addr = 8'(i);
      exp_q.push_back(ref_mem[i]);
      mid();
      chk($sformatf("t6_gnt%0d", i), ext_gnt, 1);
      if (i > 0) chk($sformatf("t6_rvalid%0d", i - 1), ext_rvalid, 1);
      next_cycle();
    end
    ext_req = 1'b0;
    mid();
    chk("t6_rvalid2", ext_rvalid, 1);
    next_cycle();
    mid();
    chk("t6_rvalid_end", ext_rvalid, 0);

    next_cycle();
    chk("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
